// File: rtl/md_cart_bridge.sv
// md_cart_bridge: cartridge-side slave that turns md_board cart strobes into single-word store requests.
// Optional SSF2-style bank mapper is built when CART_SSF2_MAPPER_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a read or write strobe edge
// RD_WAIT | mem_rd held, waiting for mem_ready
// HOLD    | read data presented on cart_data while the read strobe stays high
// WR_WAIT | mem_wr held, waiting for mem_ready
module md_cart_bridge #(
    parameter int          MEM_AW   = 24,
    parameter logic [22:0] ROM_MASK = 23'h1FFFFF
) (
    input  logic              MCLK,
    input  logic              ext_reset,
    input  logic [22:0]       cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    input  logic              cart_lwr,
    input  logic              cart_uwr,
    input  logic              cart_time,
    input  logic [15:0]       cart_data_wr,
    output logic [15:0]       cart_data,
    output logic              cart_data_en,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, HOLD, WR_WAIT} state_t;
    state_t state;

    logic [22:0]       addr_q;
    logic [15:0]       wdata_q;
    logic              cs_q, oe_q, lwr_q, uwr_q;
    logic              rd_lvl_d, wr_lvl_d;
    logic              rd_lvl, wr_lvl, rd_edge, wr_edge;
    logic [MEM_AW-1:0] rd_addr;

    always_ff @(posedge MCLK) begin
        if (ext_reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            cs_q     <= 1'b0;
            oe_q     <= 1'b0;
            lwr_q    <= 1'b0;
            uwr_q    <= 1'b0;
            rd_lvl_d <= 1'b0;
            wr_lvl_d <= 1'b0;
        end else begin
            addr_q   <= cart_address;
            wdata_q  <= cart_data_wr;
            cs_q     <= cart_cs;
            oe_q     <= cart_oe;
            lwr_q    <= cart_lwr;
            uwr_q    <= cart_uwr;
            rd_lvl_d <= rd_lvl;
            wr_lvl_d <= wr_lvl;
        end
    end

    assign rd_lvl  = cs_q & oe_q;
    assign wr_lvl  = cs_q & (lwr_q | uwr_q);
    assign rd_edge = rd_lvl & ~rd_lvl_d;
    assign wr_edge = wr_lvl & ~wr_lvl_d;

`ifdef CART_SSF2_MAPPER_EN
    // bank[0] is reset to 0 and never written, so k=0 always maps to the first 512 KiW
    logic [5:0] bank [8];
    logic       time_q, tw_lvl_d;
    logic       tw_lvl, tw_edge, bank_hit;
    logic       unused_map;

    assign tw_lvl     = time_q & lwr_q;
    assign tw_edge    = tw_lvl & ~tw_lvl_d;
    assign bank_hit   = (addr_q[6:3] == 4'hF) && (addr_q[2:0] != 3'd0);
    assign rd_addr    = MEM_AW'({bank[addr_q[21:19]], addr_q[18:0]});
    assign unused_map = addr_q[22];

    always_ff @(posedge MCLK) begin
        if (ext_reset) begin
            time_q   <= 1'b0;
            tw_lvl_d <= 1'b0;
            for (int i = 0; i < 8; i++) bank[i] <= 6'(i);
        end else begin
            time_q   <= cart_time;
            tw_lvl_d <= tw_lvl;
            if (state == IDLE && !wr_edge && tw_edge && bank_hit)
                bank[addr_q[2:0]] <= wdata_q[5:0];
        end
    end
`else
    logic unused_time;

    assign rd_addr     = MEM_AW'(addr_q & ROM_MASK);
    assign unused_time = cart_time;
`endif

    always_ff @(posedge MCLK) begin
        if (ext_reset) begin
            state        <= IDLE;
            cart_data    <= '0;
            cart_data_en <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_edge) begin
                        mem_addr  <= MEM_AW'(addr_q);
                        mem_wdata <= wdata_q;
                        mem_be    <= {uwr_q, lwr_q};
                        mem_wr    <= 1'b1;
                        state     <= WR_WAIT;
                    end else if (rd_edge) begin
                        mem_addr <= rd_addr;
                        mem_be   <= 2'b11;
                        mem_rd   <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        mem_rd    <= 1'b0;
                        cart_data <= mem_rdata;
                        state     <= rd_lvl ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (rd_lvl) begin
                        cart_data_en <= 1'b1;
                    end else begin
                        cart_data_en <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_cart_bridge.sv
// tb_md_cart_bridge: directed bench for md_cart_bridge with a request/data scoreboard.
// Expectations follow CART_SSF2_MAPPER_EN when it is defined for the build.
module tb_md_cart_bridge;
    logic        MCLK = 1'b0;
    logic        ext_reset;
    logic [22:0] cart_address;
    logic        cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time;
    logic [15:0] cart_data_wr;
    logic [15:0] cart_data;
    logic        cart_data_en;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int failures = 0;

    logic [23:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [1:0]  exp_be_q[$];
    logic [15:0] exp_wd_q[$];

    md_cart_bridge #(.MEM_AW(24), .ROM_MASK(23'h3FFFF)) dut (
        .MCLK(MCLK), .ext_reset(ext_reset), .cart_address(cart_address),
        .cart_cs(cart_cs), .cart_oe(cart_oe), .cart_lwr(cart_lwr), .cart_uwr(cart_uwr),
        .cart_time(cart_time), .cart_data_wr(cart_data_wr), .cart_data(cart_data),
        .cart_data_en(cart_data_en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 MCLK = ~MCLK;

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input logic want_wr, input string tag);
        int n = 0;
        while (((want_wr ? mem_wr : mem_rd) !== 1'b1) && n < 16) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, want_wr ? mem_wr : mem_rd}, 32'd1);
    endtask

    task automatic pulse_ready(input logic [15:0] d);
        mem_ready = 1'b1;
        mem_rdata = d;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
    endtask

    // full read: request, w wait cycles, completion, data hold, strobe release
    task automatic do_read(input logic [22:0] a, input logic [23:0] exp_a,
                           input logic [15:0] d, input int w);
        logic [15:0] exp_d;
        cart_address = a;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        exp_addr_q.push_back(exp_a);
        wait_req(1'b0, "rd_req");
        chk("rd_addr", {8'd0, mem_addr}, {8'd0, exp_addr_q.pop_front()});
        chk("rd_no_wr", {31'd0, mem_wr}, 32'd0);
        for (int i = 0; i < w; i++) begin
            tick();
            chk("rd_held", {31'd0, mem_rd}, 32'd1);
        end
        exp_data_q.push_back(d);
        pulse_ready(d);
        chk("rd_drop", {31'd0, mem_rd}, 32'd0);
        chk("en_lat1", {31'd0, cart_data_en}, 32'd0);
        tick();
        exp_d = exp_data_q.pop_front();
        chk("en_rise", {31'd0, cart_data_en}, 32'd1);
        chk("rd_data", {16'd0, cart_data}, {16'd0, exp_d});
        cart_oe = 1'b0;
        cart_cs = 1'b0;
        tick();
        chk("en_after_oe", {31'd0, cart_data_en}, 32'd1);
        tick();
        chk("en_fall", {31'd0, cart_data_en}, 32'd0);
        chk("data_kept", {16'd0, cart_data}, {16'd0, exp_d});
    endtask

    task automatic do_write(input logic [22:0] a, input logic [15:0] d,
                            input logic lw, input logic uw, input int w);
        cart_address = a;
        cart_data_wr = d;
        cart_cs = 1'b1;
        cart_lwr = lw;
        cart_uwr = uw;
        exp_addr_q.push_back({1'b0, a});
        exp_be_q.push_back({uw, lw});
        exp_wd_q.push_back(d);
        wait_req(1'b1, "wr_req");
        chk("wr_no_rd", {31'd0, mem_rd}, 32'd0);
        chk("wr_addr", {8'd0, mem_addr}, {8'd0, exp_addr_q.pop_front()});
        chk("wr_be", {30'd0, mem_be}, {30'd0, exp_be_q.pop_front()});
        chk("wr_data", {16'd0, mem_wdata}, {16'd0, exp_wd_q.pop_front()});
        for (int i = 0; i < w; i++) begin
            tick();
            chk("wr_held", {31'd0, mem_wr}, 32'd1);
        end
        pulse_ready(16'h0);
        chk("wr_drop", {31'd0, mem_wr}, 32'd0);
        cart_cs = 1'b0;
        cart_lwr = 1'b0;
        cart_uwr = 1'b0;
        tick();
    endtask

    task automatic reset_dut();
        ext_reset = 1'b1;
        tick();
        tick();
        ext_reset = 1'b0;
        tick();
    endtask

    initial begin
        ext_reset = 1'b1;
        cart_address = '0;
        cart_cs = 1'b0;
        cart_oe = 1'b0;
        cart_lwr = 1'b0;
        cart_uwr = 1'b0;
        cart_time = 1'b0;
        cart_data_wr = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_data", {16'd0, cart_data}, 32'd0);
        chk("rst_en", {31'd0, cart_data_en}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_be", {30'd0, mem_be}, 32'd0);
        chk("rst_addr", {8'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        ext_reset = 1'b0;
        tick();

        // read with wait states, address exercises mask / top bank
`ifdef CART_SSF2_MAPPER_EN
        do_read(23'h7C0123, 24'h3C0123, 16'hBEEF, 3);
`else
        do_read(23'h7C0123, 24'h000123, 16'hBEEF, 3);
`endif

        // mem_ready while idle is ignored
        pulse_ready(16'hDEAD);
        tick();
        chk("idle_rdy_en", {31'd0, cart_data_en}, 32'd0);
        chk("idle_rdy_data", {16'd0, cart_data}, 32'hBEEF);
        chk("idle_rdy_rd", {31'd0, mem_rd}, 32'd0);

        // read aborted in RD_WAIT: en never rises
        cart_address = 23'h000200;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        wait_req(1'b0, "abort_req");
        cart_oe = 1'b0;
        cart_cs = 1'b0;
        tick();
        pulse_ready(16'h5555);
        chk("abort_rd_drop", {31'd0, mem_rd}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_en", {31'd0, cart_data_en}, 32'd0);
        end
        do_read(23'h000300, 24'h000300, 16'h0F0F, 0);

        // writes: low byte, high byte, both at top address
        do_write(23'h000100, 16'h1234, 1'b1, 1'b0, 2);
        do_write(23'h000456, 16'hABCD, 1'b0, 1'b1, 0);
        do_write(23'h7FFFFF, 16'hA5A5, 1'b1, 1'b1, 1);

        // simultaneous read and write edges: write wins, read edge lost
        cart_oe = 1'b1;
        do_write(23'h000010, 16'h7777, 1'b1, 1'b0, 0);
        tick();
        chk("coinc_no_rd", {31'd0, mem_rd}, 32'd0);
        cart_oe = 1'b0;
        tick();

        // reset mid-read
        cart_address = 23'h000040;
        cart_cs = 1'b1;
        cart_oe = 1'b1;
        wait_req(1'b0, "rst_mid_req");
        ext_reset = 1'b1;
        tick();
        chk("rst_mid_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mid_en", {31'd0, cart_data_en}, 32'd0);
        cart_oe = 1'b0;
        cart_cs = 1'b0;
        tick();
        ext_reset = 1'b0;
        tick();

        // bank register write on /TIME, then read through it
        cart_address = 23'h00007A;
        cart_data_wr = 16'h0005;
        cart_time = 1'b1;
        cart_lwr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("time_no_wr", {31'd0, mem_wr}, 32'd0);
            chk("time_no_rd", {31'd0, mem_rd}, 32'd0);
        end
        cart_time = 1'b0;
        cart_lwr = 1'b0;
        tick();
`ifdef CART_SSF2_MAPPER_EN
        do_read(23'h100010, 24'h280010, 16'h1111, 1);
        reset_dut();
        do_read(23'h100010, 24'h100010, 16'h2222, 1);
        do_read(23'h140002, 24'h140002, 16'h3333, 0);
`else
        do_read(23'h100010, 24'h000010, 16'h1111, 1);
        reset_dut();
        do_read(23'h100010, 24'h000010, 16'h2222, 1);
        do_read(23'h140002, 24'h000002, 16'h3333, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
